// File: rtl/cpu_dbg_pkg.sv
// ---------------------------------------------------------------------------
// cpu_dbg_pkg
//   Shared definitions for the CPU debug-dump block:
//   - dump_state_t : FSM state encoding of cpu_dump_ctrl
//   - CAUSE_*      : dump_cause codes reported to the debugger
//   - CYCLE_W      : width of the RUN-cycle counter
//   - pick_cause() : fixed-priority trigger arbitration (halt > req > timeout)
// ---------------------------------------------------------------------------
package cpu_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_LOAD = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } dump_state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_HALT    = 2'd1;
    localparam logic [1:0] CAUSE_REQ     = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    localparam int CYCLE_W = 32;

    // Several triggers may fire in the same RUN cycle; the breakpoint is the
    // most precise information for the debugger, so it wins.
    function automatic logic [1:0] pick_cause(input logic pc_hit,
                                              input logic req_hit,
                                              input logic to_hit);
        logic [1:0] cause;
        cause = CAUSE_NONE;
        if (pc_hit)
            cause = CAUSE_HALT;
        else if (req_hit)
            cause = CAUSE_REQ;
        else if (to_hit)
            cause = CAUSE_TIMEOUT;
        return cause;
    endfunction

endpackage

// File: rtl/dbg_cycle_counter.sv
// ---------------------------------------------------------------------------
// dbg_cycle_counter
//   Saturating up-counter used to measure how long the CPU ran.
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   asynchronous active-low reset, clears count
//     clear  in   synchronous clear (priority over enable)
//     enable in   count one cycle
//     count  out  WIDTH-bit count, sticks at all-ones
// ---------------------------------------------------------------------------
module dbg_cycle_counter
    import cpu_dbg_pkg::*;
#(
    parameter int WIDTH = CYCLE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // Saturating increment: a run longer than the counter range reports the
    // maximum instead of wrapping to a misleadingly small value.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (&v)
            r = v;
        else
            r = v + WIDTH'(1);
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/cpu_dump_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_dump_ctrl
//   Lets the CPU run until a breakpoint, a manual request or a timeout, then
//   freezes it and streams the register file out one word per beat.
//   Ports:
//     clk, reset            clock, asynchronous active-low reset
//     start                 arm a run (only accepted in IDLE)
//     pc_in, halt_pc        current PC and breakpoint address
//     dump_req              manual dump trigger
//     rf_rd_addr/rf_rd_data register-file debug read (combinational data)
//     cpu_stall             freezes the CPU whenever the block is not in RUN
//     out_valid/out_ready   dump stream handshake
//     out_data/out_idx      register value and its index
//     out_last              marks the final register of the dump
//     busy, done            activity flag and end-of-dump pulse
//     dump_cause            0 none, 1 breakpoint, 2 request, 3 timeout
//     cycle_count           RUN cycles of the current or last run
// ---------------------------------------------------------------------------
module cpu_dump_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int PC_WIDTH   = 12,
    parameter  int NUM_REGS   = 8,
    parameter  int TIMEOUT    = 40,
    localparam int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [PC_WIDTH-1:0]   pc_in,
    input  logic [PC_WIDTH-1:0]   halt_pc,
    input  logic                  dump_req,
    input  logic [DATA_WIDTH-1:0] rf_rd_data,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      rf_rd_addr,
    output logic                  cpu_stall,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dump_cause,
    output logic [CYCLE_W-1:0]    cycle_count
);

    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam bit                 TO_EN    = (TIMEOUT != 0);
    localparam logic [CYCLE_W-1:0] TO_LAST  = (TIMEOUT == 0) ? '0 : CYCLE_W'(TIMEOUT - 1);

    dump_state_t      state;
    logic [IDX_W-1:0] idx;

    logic pc_hit;
    logic to_hit;
    logic trigger;
    logic cnt_clear;
    logic cnt_en;

    // Trigger detection is only meaningful in RUN; the FSM ignores it elsewhere.
    assign pc_hit  = (pc_in == halt_pc);
    assign to_hit  = TO_EN && (cycle_count == TO_LAST);
    assign trigger = pc_hit || dump_req || to_hit;

    assign cnt_clear = (state == ST_IDLE) && start;
    assign cnt_en    = (state == ST_RUN);

    dbg_cycle_counter #(
        .WIDTH (CYCLE_W)
    ) u_cycle_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (cycle_count)
    );

    // Status outputs decode straight from the state register, so an
    // asynchronous reset takes them to their idle values without a clock.
    assign cpu_stall  = (state != ST_RUN);
    assign busy       = (state != ST_IDLE);
    assign out_valid  = (state == ST_SEND);
    assign done       = (state == ST_DONE);
    assign rf_rd_addr = idx;
    assign out_last   = (out_idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            dump_cause <= CAUSE_NONE;
            out_data   <= '0;
            out_idx    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        idx        <= '0;
                        dump_cause <= CAUSE_NONE;
                    end
                end

                ST_RUN: begin
                    if (trigger) begin
                        state      <= ST_LOAD;
                        dump_cause <= pick_cause(pc_hit, dump_req, to_hit);
                    end
                end

                // One cycle for the register file to present rf_rd_data for idx.
                ST_LOAD: begin
                    out_data <= rf_rd_data;
                    out_idx  <= idx;
                    state    <= ST_SEND;
                end

                // Beat registers stay untouched until the sink accepts.
                ST_SEND: begin
                    if (out_ready) begin
                        if (out_idx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= ST_LOAD;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_dump_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_dump_ctrl
//   Self-checking bench for cpu_dump_ctrl (NUM_REGS=8, DATA_WIDTH=16,
//   PC_WIDTH=12, TIMEOUT=40, register file holds 0x1000+i).
// ---------------------------------------------------------------------------
module tb_cpu_dump_ctrl;

    localparam int DW = 16;
    localparam int PW = 12;
    localparam int NR = 8;
    localparam int TO = 40;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [PW-1:0] pc_in = '0;
    logic [PW-1:0] halt_pc = '0;
    logic          dump_req = 1'b0;
    logic [DW-1:0] rf_rd_data;
    logic          out_ready = 1'b0;
    logic [IW-1:0] rf_rd_addr;
    logic          cpu_stall;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [1:0]    dump_cause;
    logic [31:0]   cycle_count;

    logic [DW-1:0] regfile [NR];
    assign rf_rd_data = regfile[rf_rd_addr];

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         pc_cyc;   // RUN cycle (1-based) with pc_in==halt_pc, 0 = never
        int         req_cyc;  // RUN cycle with dump_req=1, 0 = never
        logic [1:0] cause;
        int         count;
        int         mode;     // 0 ready=1, 1 random ready + noise, 2 stall idx 2
    } vec_t;

    vec_t vt[8];

    cpu_dump_ctrl #(
        .DATA_WIDTH (DW),
        .PC_WIDTH   (PW),
        .NUM_REGS   (NR),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pc_in       (pc_in),
        .halt_pc     (halt_pc),
        .dump_req    (dump_req),
        .rf_rd_data  (rf_rd_data),
        .out_ready   (out_ready),
        .rf_rd_addr  (rf_rd_addr),
        .cpu_stall   (cpu_stall),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .dump_cause  (dump_cause),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_last"},  out_last, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_stall"}, cpu_stall, 1);
        chk({tag, "_data"},  out_data, 0);
        chk({tag, "_idx"},   out_idx, 0);
        chk({tag, "_raddr"}, rf_rd_addr, 0);
        chk({tag, "_cause"}, dump_cause, 0);
        chk({tag, "_count"}, cycle_count, 0);
    endtask

    // Reference: first RUN cycle at which any trigger fires, priority halt > req > timeout.
    task automatic model(input int pc_cyc, input int req_cyc,
                         output logic [1:0] cause, output int count);
        int t_pc;
        int t_req;
        int t;
        t_pc  = (pc_cyc  > 0) ? pc_cyc  : 1000;
        t_req = (req_cyc > 0) ? req_cyc : 1000;
        t = TO;
        if (t_pc < t)  t = t_pc;
        if (t_req < t) t = t_req;
        count = t;
        if (t == t_pc)       cause = 2'd1;
        else if (t == t_req) cause = 2'd2;
        else                 cause = 2'd3;
    endtask

    // One complete run + dump, starting from IDLE.
    task automatic run_dump(input int pc_cyc, input int req_cyc,
                            input logic [1:0] exp_cause, input int exp_count,
                            input int mode);
        int r;
        bit trig;
        int nexp;
        logic pv;
        logic pr;
        logic rdy;
        logic [DW-1:0] pd;
        logic [IW-1:0] pi;
        int stall_left;
        bit got_done;

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_stall", cpu_stall, 0);
        chk("run_busy", busy, 1);
        chk("run_cause_clr", dump_cause, 0);

        r = 1;
        trig = 0;
        while (!trig && r <= 100) begin
            pc_in    = (r == pc_cyc) ? halt_pc : (halt_pc ^ PW'(r | 1));
            dump_req = (r == req_cyc);
            tick();
            if (cpu_stall) trig = 1;
            else r++;
        end
        pc_in    = halt_pc ^ PW'(1);
        dump_req = 1'b0;
        chk("trig_cycle", r, exp_count);
        chk("trig_cause", dump_cause, exp_cause);
        chk("trig_count", cycle_count, exp_count);

        nexp = 0;
        pv = 0;
        pr = 0;
        pd = '0;
        pi = '0;
        stall_left = 3;
        got_done = 0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            if (done) begin
                got_done = 1;
                start = 1'b0;
                dump_req = 1'b0;
                pc_in = halt_pc ^ PW'(1);
                chk("done_beats", nexp, NR);
                chk("done_novalid", out_valid, 0);
                chk("done_cause", dump_cause, exp_cause);
                chk("done_count", cycle_count, exp_count);
            end else begin
                rdy = 1'b1;
                if (mode == 1) begin
                    rdy = 1'($urandom_range(0, 1));
                end else if (mode == 2 && out_valid && out_idx == 3'd2 && stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end
                if (pv && !pr && out_valid) begin
                    chk("hold_data", out_data, pd);
                    chk("hold_idx", out_idx, pi);
                end
                if (mode == 2 && out_valid && out_idx == 3'd2)
                    chk("bp_data", out_data, 16'h1002);
                if (out_valid && rdy) begin
                    chk("beat_idx", out_idx, nexp);
                    chk("beat_data", out_data, 16'h1000 + nexp);
                    chk("beat_last", out_last, (nexp == NR - 1));
                    nexp++;
                end
                pv = out_valid;
                pr = rdy;
                pd = out_data;
                pi = out_idx;
                out_ready = rdy;
                if (mode == 1) begin
                    start    = ($urandom_range(0, 2) == 0);
                    dump_req = 1'($urandom_range(0, 1));
                    pc_in    = $urandom_range(0, 1) ? halt_pc : (halt_pc ^ PW'(1));
                end else if (mode == 2) begin
                    // A start pulse while the sink stalls must be ignored.
                    start = out_valid && !rdy;
                end
                tick();
            end
        end
        if (!got_done) chk("done_timeout", 0, 1);
        start = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_cause", dump_cause, exp_cause);
        chk("idle_count", cycle_count, exp_count);
    endtask

    initial begin
        logic [1:0] m_cause;
        int m_count;
        int pcc;
        int rqc;
        bit seen;

        for (int i = 0; i < NR; i++) regfile[i] = DW'(16'h1000 + i);

        vt[0] = '{5,  0,  2'd1, 5,  0};  // breakpoint
        vt[1] = '{0,  0,  2'd3, 40, 0};  // timeout
        vt[2] = '{0,  3,  2'd2, 3,  2};  // manual request with backpressure on idx 2
        vt[3] = '{7,  7,  2'd1, 7,  0};  // simultaneous halt + request
        vt[4] = '{1,  0,  2'd1, 1,  0};  // breakpoint on first RUN cycle
        vt[5] = '{0,  40, 2'd2, 40, 2};  // request coincides with timeout
        vt[6] = '{45, 0,  2'd3, 40, 0};  // breakpoint too late
        vt[7] = '{20, 10, 2'd2, 10, 0};  // request earlier than breakpoint

        halt_pc = 12'h00C;
        pc_in = 12'h000;
        repeat (2) tick();
        chk_reset_values("rst");
        reset = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);

        // Triggers in IDLE must not start anything.
        pc_in = halt_pc;
        dump_req = 1'b1;
        tick();
        tick();
        chk("idle_ignore_busy", busy, 0);
        chk("idle_ignore_stall", cpu_stall, 1);
        dump_req = 1'b0;

        for (int v = 0; v < 8; v++)
            run_dump(vt[v].pc_cyc, vt[v].req_cyc, vt[v].cause, vt[v].count, vt[v].mode);

        for (int n = 0; n < 12; n++) begin
            halt_pc = PW'($urandom);
            pcc = $urandom_range(0, 50);
            rqc = $urandom_range(0, 50);
            model(pcc, rqc, m_cause, m_count);
            run_dump(pcc, rqc, m_cause, m_count, 1);
        end

        // Reset in the middle of a dump, while idx 4 is presented.
        halt_pc = 12'h00C;
        start = 1'b1;
        tick();
        start = 1'b0;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            if (out_valid && out_idx == 3'd4) seen = 1;
            else tick();
        end
        chk("mid_reach_idx4", seen, 1);
        chk("mid_valid_before", out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_values("async_rst");
        tick();
        tick();
        out_ready = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("after_rst_idle", busy, 0);
            chk("after_rst_novalid", out_valid, 0);
        end
        run_dump(5, 0, 2'd1, 5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cpu_dump_ctrl.md
CPU_DUMP_CTRL -- requirements
Module: cpu_dump_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16: register-file word width.
REQ-002 Parameter PC_WIDTH, default 12: program-counter width.
REQ-003 Parameter NUM_REGS, default 8: registers dumped, minimum 2; IDX_W = clog2(NUM_REGS).
REQ-004 Parameter TIMEOUT, default 40: RUN-cycle limit; 0 disables the timeout.
REQ-005 clk  in  1  single clock, all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  arms a run; honoured only in IDLE.
REQ-008 pc_in  in  PC_WIDTH  current CPU program counter.
REQ-009 halt_pc  in  PC_WIDTH  breakpoint address.
REQ-010 dump_req  in  1  manual dump trigger.
REQ-011 rf_rd_data  in  DATA_WIDTH  combinational register-file read data for rf_rd_addr.
REQ-012 out_ready  in  1  sink accepts a beat.
REQ-013 rf_rd_addr  out  IDX_W  register-file debug read address.
REQ-014 cpu_stall  out  1  freezes the CPU pipeline.
REQ-015 out_valid / out_data / out_idx / out_last  out  1 / DATA_WIDTH / IDX_W / 1  dump stream.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse at the end of a dump.
REQ-018 dump_cause  out  2  0 none, 1 halt_pc, 2 dump_req, 3 timeout.
REQ-019 cycle_count  out  32  RUN cycles in the current or last run.

Function
REQ-020 The FSM SHALL have the states IDLE, RUN, LOAD, SEND and DONE.
REQ-021 IDLE with start=1 SHALL move to RUN next cycle and SHALL clear cycle_count, dump_cause and the index.
REQ-022 RUN SHALL increment cycle_count every cycle, saturating at 2^32-1.
REQ-023 A trigger in RUN SHALL be pc_in==halt_pc, dump_req=1, or (TIMEOUT!=0 and cycle_count==TIMEOUT-1); a trigger moves the FSM to LOAD next cycle.
REQ-024 Trigger priority SHALL be halt_pc > dump_req > timeout; dump_cause latches the winning cause on the trigger edge.
REQ-025 cpu_stall SHALL equal (state != RUN).
REQ-026 In LOAD, rf_rd_addr SHALL equal the index; at the end of that cycle out_data captures rf_rd_data, out_idx captures the index, and the FSM moves to SEND.
REQ-027 In SEND, out_valid SHALL be 1; out_data, out_idx and out_last SHALL be held stable while out_ready=0.
REQ-028 out_last SHALL equal (out_idx == NUM_REGS-1).
REQ-029 On out_valid & out_ready:
- with out_last, the FSM moves to DONE;
- otherwise the index increments and the FSM returns to LOAD.
REQ-030 DONE SHALL assert done for one cycle, then go to IDLE; dump_cause and cycle_count hold until the next accepted start.
REQ-031 start, dump_req and halt_pc matches SHALL be ignored outside the states in which REQ-021/REQ-023 apply.
REQ-032 out_valid SHALL be 0 in every state except SEND.

Reset
REQ-033 While reset=0, regardless of clk:
- state is IDLE, index 0, cpu_stall 1;
- out_valid, out_last, done and busy are 0;
- out_data, out_idx, rf_rd_addr, dump_cause and cycle_count are 0.
REQ-034 Reset asserted mid-dump SHALL abort the dump with no further beats; after release the block waits in IDLE for start.

Structure
REQ-035 A shared package cpu_dbg_pkg SHALL hold the FSM state encoding and the dump_cause constants.
REQ-036 The saturating run counter SHALL be a sub-module dbg_cycle_counter, with clear, enable and count ports.

Verification (NUM_REGS=8, DATA_WIDTH=16, TIMEOUT=40, regfile preloaded 0x1000+i)
REQ-037 Breakpoint: halt_pc=0x00C, start, pc_in=0x00C on RUN cycle 5, out_ready=1.
- Required: cpu_stall=1 from the next cycle, dump_cause=1, cycle_count=5.
- Required: 8 beats idx 0..7 with data 0x1000..0x1007, out_last only on idx 7, then one done pulse.
REQ-038 Timeout: pc_in never matches. Required: after 40 RUN cycles dump_cause=3, cycle_count=40, 8 beats follow.
REQ-039 Backpressure: out_ready=0 for 3 cycles while idx 2 is presented. Required: out_data holds 0x1002 throughout; no beat skipped or duplicated.
REQ-040 Simultaneous triggers: pc match and dump_req in the same cycle. Required: dump_cause=1.
REQ-041 Reset mid-dump: reset=0 during idx 4. Required:
- out_valid drops without waiting for a clock edge;
- all outputs take their reset values;
- after release, a new start yields a full dump from idx 0.
REQ-042 start pulsed during SEND. Required: ignored; cycle_count and dump_cause unchanged.
